reg_write_arbiter: RTL and testbench

//  Shares one WIDTH-bit enable-gated register among NUM_REQ requesters.

---
 rtl/reg_write_arbiter_pkg.sv | 20 ++
 rtl/reg_write_arbiter_if.sv | 31 +++
 rtl/reg_write_arbiter_flip_flop.sv | 16 +
 rtl/reg_write_arbiter.sv | 138 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and defaults for the register write arbiter.
package reg_write_arbiter_pkg;

  // Default geometry: four requesters sharing a 16-bit status/config word.
  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefMaxLock = 4;

  // Arbiter states: IDLE arbitrates round-robin, LOCKED holds the current owner.
  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  // Index width for a set of n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register write arbiter.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth
) ();

  localparam int unsigned OwnerW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       grant;
  logic [OwnerW-1:0]        owner;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;

  // Requesters drive requests and data and observe grants and the register.
  modport master (
    output req, lock, wdata,
    input  grant, owner, q, q_valid
  );

  // The arbiter consumes requests and presents grants and the register.
  modport slave (
    input  req, lock, wdata,
    output grant, owner, q, q_valid
  );

endinterface

// File: rtl/reg_write_arbiter_flip_flop.sv
// Single enable-gated storage bit; the shared register is a row of these.
module reg_write_arbiter_flip_flop (
  input  logic clk,
  input  logic enable,
  input  logic d,
  output logic q
);

  // Capture d only when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter with capped lock bursts guarding one shared register.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DefNumReq,
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned MAX_LOCK = DefMaxLock
) (
  input logic                  clk,
  input logic                  reset,
  reg_write_arbiter_if.slave   bus
);

  localparam int unsigned PtrW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_LOCK);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                q_valid_q, q_valid_d;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rr_mask;
  logic                rr_found;
  logic [PtrW-1:0]     rr_idx;
  logic [PtrW-1:0]     cand;
  logic [WIDTH-1:0]    wsel;
  logic [WIDTH-1:0]    ff_d;
  logic [WIDTH-1:0]    ff_q;
  logic                ff_en;

  // The locked owner is excluded from the search once its burst is exhausted.
  assign rr_mask = (state_q == StLocked) ? (NUM_REQ'(1) << owner_q) : '0;

  // Round-robin search: first unmasked request starting at ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!rr_found && bus.req[cand] && !rr_mask[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next-state, grant and bookkeeping; reset low suppresses every grant.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant     = '0;
    if (!reset) begin
      state_d = StIdle;
    end else if (state_q == StLocked && cnt_q != CntMax) begin
      // Burst still has budget: only the owner can be served.
      if (bus.req[owner_q]) begin
        grant[owner_q] = 1'b1;
        if (bus.lock[owner_q]) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if (rr_found) begin
      // Idle, or a capped burst falling back to round-robin from ptr.
      grant[rr_idx] = 1'b1;
      owner_d       = rr_idx;
      ptr_d         = (rr_idx == LastIdx) ? '0 : rr_idx + PtrW'(1);
      if (bus.lock[rr_idx]) begin
        state_d = StLocked;
        cnt_d   = CntW'(1);
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else begin
      state_d = StIdle;
      cnt_d   = '0;
    end
    q_valid_d = q_valid_q | (|grant);
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Grant is one-hot, so OR-ing the gated lanes selects the winner's data.
  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wsel = wsel | bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset forces a write of zero; otherwise write only on a grant.
  assign ff_en = !reset | (|grant);
  assign ff_d  = reset ? wsel : '0;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bits
    reg_write_arbiter_flip_flop u_bit (
      .clk    (clk),
      .enable (ff_en),
      .d      (ff_d[b]),
      .q      (ff_q[b])
    );
  end

  assign bus.grant   = grant;
  assign bus.owner   = owner_q;
  assign bus.q       = ff_q;
  assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench: stimulus pushes expectations, a negedge monitor checks them.
module tb_reg_write_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned Width   = 16;
  localparam int unsigned MaxLock = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  reg_write_arbiter_if #(.NUM_REQ(NumReq), .WIDTH(Width)) bus ();

  reg_write_arbiter #(
    .NUM_REQ  (NumReq),
    .WIDTH    (Width),
    .MAX_LOCK (MaxLock)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  grant;
    logic [15:0] q;
    logic        qv;
    logic [1:0]  owner;
    logic        chk_regs;
  } exp_t;

  exp_t  sb[$];
  string names[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge and record what must be seen.
  task automatic step(input string nm, input logic rst, input logic [3:0] r,
                      input logic [3:0] l, input logic [63:0] wd, input logic [3:0] g,
                      input logic [15:0] eq, input logic eqv, input logic [1:0] eo,
                      input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    bus.req   = r;
    bus.lock  = l;
    bus.wdata = wd;
    e.grant    = g;
    e.q        = eq;
    e.qv       = eqv;
    e.owner    = eo;
    e.chk_regs = chk;
    sb.push_back(e);
    names.push_back(nm);
  endtask

  // Monitor: mid-cycle, pop the oldest expectation and compare.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        nm = names.pop_front();
        cmp(nm, "grant", 16'(bus.grant), 16'(e.grant));
        if (e.chk_regs) begin
          cmp(nm, "q", bus.q, e.q);
          cmp(nm, "q_valid", 16'(bus.q_valid), 16'(e.qv));
          cmp(nm, "owner", 16'(bus.owner), 16'(e.owner));
        end
      end
    end
  end

  initial begin
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;

    // Reset dominates all requests.
    step("rst0", 1'b0, 4'b1111, 4'b0000, 64'h0, 4'b0000, 16'h0, 1'b0, 2'd0, 1'b0);
    step("rst1", 1'b0, 4'b1111, 4'b0000, 64'h0, 4'b0000, 16'h0, 1'b0, 2'd0, 1'b1);
    step("rst2", 1'b0, 4'b1111, 4'b0000, 64'h0, 4'b0000, 16'h0, 1'b0, 2'd0, 1'b1);

    // Round-robin with all requesting; q lags grant by one cycle.
    step("rr0", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b0001, 16'h0000, 1'b0, 2'd0, 1'b1);
    step("rr1", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b0010, 16'h00A0, 1'b1, 2'd0, 1'b1);
    step("rr2", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b0100, 16'h00A1, 1'b1, 2'd1, 1'b1);
    step("rr3", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b1000, 16'h00A2, 1'b1, 2'd2, 1'b1);
    step("rr4", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b0001, 16'h00A3, 1'b1, 2'd3, 1'b1);
    step("rr5", 1'b1, 4'b1111, 4'b0000, 64'h00A3_00A2_00A1_00A0, 4'b0010, 16'h00A0, 1'b1, 2'd0, 1'b1);

    // Burst from ptr=2: four grants to 2, then forced release to requester 0.
    step("bst0", 1'b1, 4'b0101, 4'b0100, 64'h0000_2222_0000_1111, 4'b0100, 16'h00A1, 1'b1, 2'd1, 1'b1);
    step("bst1", 1'b1, 4'b0101, 4'b0100, 64'h0000_2222_0000_1111, 4'b0100, 16'h2222, 1'b1, 2'd2, 1'b1);
    step("bst2", 1'b1, 4'b0101, 4'b0100, 64'h0000_2222_0000_1111, 4'b0100, 16'h2222, 1'b1, 2'd2, 1'b1);
    step("bst3", 1'b1, 4'b0101, 4'b0100, 64'h0000_2222_0000_1111, 4'b0100, 16'h2222, 1'b1, 2'd2, 1'b1);
    step("bst4", 1'b1, 4'b0101, 4'b0100, 64'h0000_2222_0000_1111, 4'b0001, 16'h2222, 1'b1, 2'd2, 1'b1);

    // Early release: owner 1 drops lock on its second grant, then pending 3 wins.
    step("erl0", 1'b1, 4'b1010, 4'b0010, 64'h3333_0000_3331_0000, 4'b0010, 16'h1111, 1'b1, 2'd0, 1'b1);
    step("erl1", 1'b1, 4'b1010, 4'b0000, 64'h3333_0000_3331_0000, 4'b0010, 16'h3331, 1'b1, 2'd1, 1'b1);
    step("erl2", 1'b1, 4'b1010, 4'b0000, 64'h3333_0000_3331_0000, 4'b1000, 16'h3331, 1'b1, 2'd1, 1'b1);

    // Reset on the second locked cycle clears everything and restarts at ptr 0.
    step("mrs0", 1'b1, 4'b0001, 4'b0001, 64'h0000_0000_5551_5550, 4'b0001, 16'h3333, 1'b1, 2'd3, 1'b1);
    step("mrs1", 1'b0, 4'b0001, 4'b0001, 64'h0000_0000_5551_5550, 4'b0000, 16'h5550, 1'b1, 2'd0, 1'b1);
    step("mrs2", 1'b1, 4'b0011, 4'b0000, 64'h0000_0000_5551_5550, 4'b0001, 16'h0000, 1'b0, 2'd0, 1'b1);
    step("mrs3", 1'b1, 4'b0000, 4'b0000, 64'h0000_0000_5551_5550, 4'b0000, 16'h5550, 1'b1, 2'd0, 1'b1);

    // Idle hold: one write of BEEF, then nothing requests.
    step("hld0", 1'b1, 4'b0100, 4'b0000, 64'h0000_BEEF_0000_0000, 4'b0100, 16'h5550, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("hld", 1'b1, 4'b0000, 4'b0010, 64'h1234_5678_9ABC_DEF0, 4'b0000, 16'hBEEF, 1'b1, 2'd2, 1'b1);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
